// File: rtl/secded_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : secded_dec_pipe
// Purpose  : Two-stage pipelined Hsiao SECDED decoder with valid/ready flow
//            control, saturating error counters and first-UE syndrome log.
// Revision : 1.0 - initial release
// ============================================================================
module secded_dec_pipe #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W+CHK_W-1:0]  in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W+CHK_W-1:0]  out,
   output logic [CHK_W-1:0]         syn,
   output logic                     sgl,
   output logic                     dbl,
   input  logic                     cnt_clr,
   output logic [CNT_W-1:0]         ce_cnt,
   output logic [CNT_W-1:0]         ue_cnt,
   output logic                     ue_log_vld,
   output logic [CHK_W-1:0]         ue_log_syn
);

   localparam int N       = DATA_W + CHK_W;
   localparam int CHK_MIN = (DATA_W <= 32) ? 7 : 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Number of available odd-weight (3 or 5) columns for this check width.
   function automatic int n_cols();
      int cnt;
      cnt = 0;
      for (int v = 1; v < (1 << CHK_W); v++) begin
         if ($countones(v) == 3 || $countones(v) == 5) cnt++;
      end
      return cnt;
   endfunction

   // H-matrix column for codeword bit b: data bits take the b-th odd-weight
   // vector (weight 3 ascending, then weight 5 ascending); check bits are unit.
   function automatic logic [CHK_W-1:0] col_of(input int b);
      int               cnt;
      logic [CHK_W-1:0] col;
      cnt = 0;
      col = '0;
      if (b >= DATA_W) begin
         col[b - DATA_W] = 1'b1;
      end else begin
         for (int w = 3; w <= 5; w += 2) begin
            for (int v = 1; v < (1 << CHK_W); v++) begin
               if ($countones(v) == w) begin
                  if (cnt == b) col = v[CHK_W-1:0];
                  cnt++;
               end
            end
         end
      end
      return col;
   endfunction

   if (DATA_W < 8 || DATA_W > 64 || CHK_W < CHK_MIN || n_cols() < DATA_W) begin : g_param_check
      $error("secded_dec_pipe: unsupported DATA_W/CHK_W combination");
   end

   logic                r_v1;
   logic [N-1:0]        r_s1_cw;
   logic [CHK_W-1:0]    r_s1_syn;
   logic [CHK_W-1:0]    w_col_term [N];
   logic [N-1:0]        w_match;
   logic [CHK_W-1:0]    w_syn;
   logic [N-1:0]        w_cw_corr;
   logic                w_sgl;
   logic                w_dbl;
   logic                w_adv1;
   logic                w_adv2;
   logic                w_xfer;
   logic [CNT_W-1:0]    w_ce_base;
   logic [CNT_W-1:0]    w_ue_base;
   logic [CNT_W-1:0]    w_ce_nxt;
   logic [CNT_W-1:0]    w_ue_nxt;
   logic                w_log_vld_base;
   logic [CHK_W-1:0]    w_log_syn_base;
   logic                w_log_vld_nxt;
   logic [CHK_W-1:0]    w_log_syn_nxt;

   // Per-bit H column contribution for stage 1 and column match for stage 2.
   for (genvar b = 0; b < N; b++) begin : g_col
      localparam logic [CHK_W-1:0] COL = col_of(b);
      assign w_col_term[b] = in[b] ? COL : '0;
      assign w_match[b]    = (r_s1_syn == COL);
   end

   assign w_adv2   = ~out_valid | out_ready;
   assign w_adv1   = ~r_v1 | w_adv2;
   assign in_ready = w_adv1;
   assign w_xfer   = out_valid & out_ready;

   // Syndrome of the incoming codeword: XOR of the columns of all set bits.
   always_comb begin
      w_syn = '0;
      for (int b = 0; b < N; b++) w_syn = w_syn ^ w_col_term[b];
   end

   // Classification: a column match can only occur for an odd-weight syndrome,
   // so the match vector doubles as the single-bit flip mask.
   always_comb begin
      w_sgl     = |w_match;
      w_dbl     = (r_s1_syn != '0) && !w_sgl;
      w_cw_corr = r_s1_cw ^ w_match;
   end

   // Stage 1: capture codeword and its syndrome.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1     <= 1'b0;
         r_s1_cw  <= '0;
         r_s1_syn <= '0;
      end else if (w_adv1) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_s1_cw  <= in;
            r_s1_syn <= w_syn;
         end
      end
   end

   // Stage 2: capture corrected word and classification; holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         syn       <= '0;
         sgl       <= 1'b0;
         dbl       <= 1'b0;
      end else if (w_adv2) begin
         out_valid <= r_v1;
         if (r_v1) begin
            out <= w_cw_corr;
            syn <= r_s1_syn;
            sgl <= w_sgl;
            dbl <= w_dbl;
         end
      end
   end

   // Counter/log next state: clear first, then apply this cycle's transfer.
   always_comb begin
      w_ce_base      = cnt_clr ? '0 : ce_cnt;
      w_ue_base      = cnt_clr ? '0 : ue_cnt;
      w_log_vld_base = cnt_clr ? 1'b0 : ue_log_vld;
      w_log_syn_base = cnt_clr ? '0 : ue_log_syn;
      w_ce_nxt       = w_ce_base;
      w_ue_nxt       = w_ue_base;
      w_log_vld_nxt  = w_log_vld_base;
      w_log_syn_nxt  = w_log_syn_base;
      if (w_xfer && sgl && (w_ce_base != CNT_MAX)) w_ce_nxt = w_ce_base + CNT_W'(1);
      if (w_xfer && dbl && (w_ue_base != CNT_MAX)) w_ue_nxt = w_ue_base + CNT_W'(1);
      if (w_xfer && dbl && !w_log_vld_base) begin
         w_log_vld_nxt = 1'b1;
         w_log_syn_nxt = syn;
      end
   end

   // Counter and log registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_cnt     <= '0;
         ue_cnt     <= '0;
         ue_log_vld <= 1'b0;
         ue_log_syn <= '0;
      end else begin
         ce_cnt     <= w_ce_nxt;
         ue_cnt     <= w_ue_nxt;
         ue_log_vld <= w_log_vld_nxt;
         ue_log_syn <= w_log_syn_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_secded_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_secded_dec_pipe
// Purpose  : Self-checking bench for secded_dec_pipe (DATA_W=32) with a
//            second instance at CNT_W=2 sharing stimulus for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secded_dec_pipe;

   localparam int N = 39;

   typedef struct packed {
      logic [N-1:0] cw;
      logic [6:0]   syn;
      logic         sgl;
      logic         dbl;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          cnt_clr = 1'b0;
   logic [N-1:0]  in_w = '0;

   logic          in_ready, out_valid, sgl, dbl, log_vld;
   logic [N-1:0]  out_w;
   logic [6:0]    syn, log_syn;
   logic [15:0]   ce_cnt, ue_cnt;

   logic          in_ready_s, out_valid_s, sgl_s, dbl_s, log_vld_s;
   logic [N-1:0]  out_s;
   logic [6:0]    syn_s, log_syn_s;
   logic [1:0]    ce_s, ue_s;

   logic [6:0]    cols [N];
   res_t          exp_q [$];
   int            model_ce, model_ue;
   logic          model_log_vld;
   logic [6:0]    model_log_syn;
   logic          hold_pending;
   res_t          hold;
   logic          last_acc;
   int            n_xfer;
   int            total, passes, fails;

   secded_dec_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_w),
      .out_valid(out_valid), .out_ready(out_ready), .out(out_w), .syn(syn), .sgl(sgl),
      .dbl(dbl), .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
      .ue_log_vld(log_vld), .ue_log_syn(log_syn)
   );

   secded_dec_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in(in_w),
      .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s), .syn(syn_s), .sgl(sgl_s),
      .dbl(dbl_s), .cnt_clr(cnt_clr), .ce_cnt(ce_s), .ue_cnt(ue_s),
      .ue_log_vld(log_vld_s), .ue_log_syn(log_syn_s)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // Reference decoder: syndrome from H columns, clean / single / uncorrectable.
   function automatic res_t ref_decode(input logic [N-1:0] w);
      res_t       r;
      logic [6:0] s;
      s = '0;
      for (int b = 0; b < N; b++) if (w[b]) s ^= cols[b];
      r.cw = w; r.syn = s; r.sgl = 1'b0; r.dbl = 1'b0;
      if (s != 0) begin
         r.dbl = 1'b1;
         for (int b = 0; b < N; b++) begin
            if (cols[b] == s) begin
               r.dbl = 1'b0;
               r.sgl = 1'b1;
               r.cw[b] = ~w[b];
            end
         end
      end
      return r;
   endfunction

   // Valid codeword from random data, then 0..3 random bit flips.
   function automatic logic [N-1:0] rand_word();
      logic [31:0]  d;
      logic [6:0]   c;
      logic [N-1:0] w;
      int           nf;
      d = $urandom;
      c = '0;
      for (int b = 0; b < 32; b++) if (d[b]) c ^= cols[b];
      w = {c, d};
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) w[$urandom_range(0, N-1)] ^= 1'b1;
      return w;
   endfunction

   // One clock: sample at the falling edge, check, update model, return at posedge+1.
   task automatic step();
      logic acc, xfr;
      res_t e;
      @(negedge clk);
      acc = in_valid && in_ready;
      xfr = out_valid && out_ready;
      chk("ce_cnt", ce_cnt, model_ce);
      chk("ue_cnt", ue_cnt, model_ue);
      chk("log_vld", log_vld, model_log_vld);
      chk("log_syn", log_syn, model_log_syn);
      chk("sat_ce", ce_s, sat3(model_ce));
      chk("sat_ue", ue_s, sat3(model_ue));
      chk("sat_log_syn", log_syn_s, model_log_syn);
      chk("sat_in_ready", in_ready_s, in_ready);
      if (hold_pending) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_cw", out_w, hold.cw);
         chk("hold_syn", syn, hold.syn);
         chk("hold_flags", {sgl, dbl}, {hold.sgl, hold.dbl});
      end
      if (cnt_clr) begin
         model_ce = 0; model_ue = 0; model_log_vld = 1'b0; model_log_syn = '0;
      end
      if (xfr) begin
         n_xfer++;
         chk("out_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_cw", out_w, e.cw);
            chk("out_syn", syn, e.syn);
            chk("out_sgl", sgl, e.sgl);
            chk("out_dbl", dbl, e.dbl);
            if (e.sgl) model_ce++;
            if (e.dbl) begin
               model_ue++;
               if (!model_log_vld) begin
                  model_log_vld = 1'b1;
                  model_log_syn = e.syn;
               end
            end
         end
      end
      hold_pending = out_valid && !out_ready;
      hold = '{cw: out_w, syn: syn, sgl: sgl, dbl: dbl};
      if (acc) exp_q.push_back(ref_decode(in_w));
      last_acc = acc;
      @(posedge clk);
      #1;
   endtask

   // Send one word into an idle pipe and check its presentation 2 cycles later.
   task automatic send_one(input string tag, input logic [N-1:0] w, input logic [N-1:0] eo,
                           input logic [6:0] es, input logic esg, input logic edb);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_w = w;
      step();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      step();
      chk({tag, "_lat2"}, out_valid, 1);
      chk({tag, "_out"}, out_w, eo);
      chk({tag, "_syn"}, syn, es);
      chk({tag, "_flags"}, {sgl, dbl}, {esg, edb});
      step();
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      step();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic [N-1:0] stall_w [4];
      int           idx;
      total = 0; passes = 0; fails = 0; n_xfer = 0;
      model_ce = 0; model_ue = 0; model_log_vld = 1'b0; model_log_syn = '0;
      hold_pending = 1'b0; last_acc = 1'b0;
      hold = '0;
      begin
         int k;
         k = 0;
         for (int w = 3; w <= 5; w += 2)
            for (int v = 1; v < 128; v++)
               if ($countones(v) == w && k < 32) begin
                  cols[k] = v[6:0];
                  k++;
               end
         for (int j = 0; j < 7; j++) cols[32+j] = 7'(1 << j);
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out", out_w, 0);
      chk("rst_syn", syn, 0);
      chk("rst_flags", {sgl, dbl}, 2'b00);
      chk("rst_cnts", {ce_cnt, ue_cnt, log_vld, log_syn}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed single words
      send_one("clean", 39'h0, 39'h0, 7'h00, 1'b0, 1'b0);
      chk("clean_ce", ce_cnt, 0);
      send_one("bit0", 39'h1, 39'h0, 7'h07, 1'b1, 1'b0);
      chk("bit0_ce", ce_cnt, 1);
      send_one("chk32", 39'h1_0000_0000, 39'h0, 7'h01, 1'b1, 1'b0);
      chk("chk32_ce", ce_cnt, 2);
      send_one("dbl01", 39'h3, 39'h3, 7'h0C, 1'b0, 1'b1);
      chk("dbl01_ue", ue_cnt, 1);
      chk("dbl01_log", {log_vld, log_syn}, {1'b1, 7'h0C});
      send_one("dbl12", 39'h6, 39'h6, 7'h06, 1'b0, 1'b1);
      chk("dbl12_ue", ue_cnt, 2);
      chk("dbl12_log", {log_vld, log_syn}, {1'b1, 7'h0C});

      // Back-to-back singles against a 5-cycle output stall
      stall_w[0] = 39'h8; stall_w[1] = 39'h400; stall_w[2] = 39'h10_0000; stall_w[3] = 39'h8_0000_0000;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 16 && idx < 4; c++) begin
         if (c == 5) out_ready = 1'b1;
         in_valid = 1'b1;
         in_w = stall_w[idx];
         step();
         if (last_acc) idx++;
         if (c == 2) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_accepted", idx, 2);
         end
      end
      chk("stall_all_accepted", idx, 4);
      drain();
      chk("stall_ce", ce_cnt, 6);
      chk("sat_ce_3", ce_s, 3);

      // Clear coinciding with an uncorrectable transfer
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_w = 39'hC;
      step();
      in_valid = 1'b0;
      step();
      step();
      cnt_clr = 1'b1;
      out_ready = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_ce", ce_cnt, 0);
      chk("clr_ue", ue_cnt, 1);
      chk("clr_log", {log_vld, log_syn}, {1'b1, 7'h03});
      chk("clr_sat", {ce_s, ue_s}, {2'd0, 2'd1});

      // Randomised traffic with random back-pressure
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_w      = rand_word();
         step();
      end
      drain();

      // Asynchronous reset with two words in flight
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_w = rand_word();
      step();
      in_w = rand_word();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_cnts", {ce_cnt, ue_cnt, log_vld}, 0);
      chk("arst_sat_cnts", {ce_s, ue_s, log_vld_s}, 0);
      in_valid = 1'b0;
      exp_q.delete();
      model_ce = 0; model_ue = 0; model_log_vld = 1'b0; model_log_syn = '0;
      hold_pending = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_xfer = 0;
      send_one("post_rst", 39'h0, 39'h0, 7'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("post_rst_single", n_xfer, 1);
      chk("post_rst_idle", out_valid, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
`default_nettype wire
